mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Consumer end of the load/store control interface: takes the decoded memory controls (MemRead, MemWrite, MuxLoad, MuxStore) plus the ALU effective address and store data from the EX/M stage, and runs one data-memory transaction per request over a req/ack handshake. Generates byte enables and lane-replicated write data for stores. For loads, extracts and sign-extends the addressed byte or halfword. Holds Busy high for the whole transaction so the pipeline stalls; flags misaligned or unsupported accesses and memory timeouts.

Parameters:
TIMEOUT, 16, cycles MemReq may stay unacknowledged before the bus error fires (>=1)
AW, 32, address width

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Start  in  1  request valid; sampled only in IDLE
MemRead  in  1  load request
MemWrite  in  2  store request; bit 0 used, bit 1 must be 0
MuxLoad  in  2  load size: 00 word, 01 halfword, 10 byte, 11 reserved
MuxStore  in  2  store size: same encoding as MuxLoad
Addr  in  AW  effective address from the ALU
StoreData  in  32  rt value; low bits hold the sub-word
Busy  out  1  high from the cycle after an accepted Start until Done
Done  out  1  one-cycle completion pulse
LoadData  out  32  sign-extended load result; valid with Done, held until next Done
AddrErr  out  1  pulses with Done: misaligned, reserved size, or read+write both set
BusErr  out  1  pulses with Done on timeout
MemReq  out  1  memory request, held until ack
MemWe  out  1  1 = write
MemAddr  out  AW  word address {Addr[AW-1:2],2'b00}
MemBE  out  4  byte enables, lane 0 = bits 7:0 (little-endian)
MemWData  out  32  lane-replicated write data
MemAck  in  1  memory accepted or returned data this cycle
MemRData  in  32  read word; valid when MemAck=1 on a read

Behaviour:
- Reset (async, Rst_n=0): state IDLE. All outputs 0, including LoadData and the timeout counter. MemReq drops immediately, even in the middle of a transaction. No Done is produced for an aborted access.
- FSM states are IDLE, REQ, RESP.
- IDLE with Start=1 and a valid request: register the request fields and go to REQ. Busy=1 and MemReq=1 from the next cycle.
- IDLE with Start=1 and neither MemRead nor MemWrite[0] set: go to RESP. No memory access; Done pulses next cycle with no error.
- IDLE with Start=1 and an illegal request: go to RESP with AddrErr set, and never assert MemReq. Illegal requests are:
  - halfword with Addr[0]=1
  - word with Addr[1:0]!=0
  - size code 11
  - MemRead and MemWrite[0] both set
- REQ: MemReq, MemWe, MemAddr, MemBE and MemWData stay stable until MemAck=1 is sampled. On ack: capture LoadData (for reads), drop MemReq, go to RESP.
- REQ timeout: the counter increments each REQ cycle without ack. When the count reaches TIMEOUT, drop MemReq, set BusErr, go to RESP; LoadData is left unchanged. If ack arrives in the same cycle the count reaches TIMEOUT, the ack wins and there is no BusErr.
- RESP: Done=1 (with AddrErr/BusErr as applicable) for exactly one cycle, Busy=0, return to IDLE. A Start that arrives in RESP is ignored, so back-to-back requests are spaced by at least one IDLE cycle.
- Latency: if ack arrives in the first REQ cycle, Done comes 2 cycles after Start.
- Store byte: MemBE=4'b0001<<Addr[1:0], MemWData={4{StoreData[7:0]}}.
- Store halfword: MemBE = Addr[1] ? 1100 : 0011, MemWData={2{StoreData[15:0]}}.
- Store word: MemBE=1111, MemWData=StoreData.
- Reads: MemBE=1111. Byte load selects lane Addr[1:0] and sign-extends bit 7; halfword selects the half given by Addr[1] and sign-extends bit 15; word load passes MemRData through.
- Busy=1 in REQ only. Inputs may change freely once Start has been accepted.

Decomposition:
- Shared package (mips_ctrl_pkg): size encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10, SZ_RSVD=2'b11, and the FSM state constants.
- Sub-module lane_align (combinational): computes BE, replicated write data, and load extract/sign-extend from size, Addr[1:0] and data. It is reusable by the future cache path.

Test Plan:
1. Byte store: Start, MemWrite=1, MuxStore=10, Addr=0x1003, StoreData=0x000000A5, ack in the first REQ cycle -> MemAddr=0x1000, MemBE=1000, MemWData=0xA5A5A5A5; Done 2 cycles after Start, no errors.
2. Halfword load: MemRead=1, MuxLoad=01, Addr=0x2002, MemRData=0x8001_1234, ack after 3 wait cycles -> LoadData=0xFFFF8001, Busy held 4 cycles, one-cycle Done.
3. Misaligned word load at Addr=0x0006 -> no MemReq ever; Done and AddrErr one cycle after Start. Also run MuxStore=11 and read+write both set -> same response.
4. Timeout: TIMEOUT=4, no ack -> MemReq high exactly 4 cycles, then Done+BusErr, LoadData unchanged. Repeat with ack in the 4th cycle -> normal Done, no BusErr.
5. Async reset asserted mid-REQ -> MemReq, Busy and LoadData go to 0 without waiting for a clock edge; no Done. After release, a new lb from 0x0000 with MemRData=0x0000007F -> LoadData=0x0000007F.
6. Start held high continuously with ack in the first REQ cycle -> transactions spaced IDLE, REQ, RESP; the Start seen in RESP is ignored, and each accepted Start yields exactly one Done.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared load/store control encodings and state constants for the memory access path.
package mips_ctrl_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True when the low address bits are naturally aligned for the access size.
    function automatic logic size_ok(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_WORD: return offset == 2'b00;
            SZ_HALF: return !offset[0];
            SZ_BYTE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering: store byte enables and replicated data, load extract and sign-extend.
module lane_align
    import mips_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        write,
    input  logic [31:0] store_data,
    input  logic [31:0] read_word,
    output logic [3:0]  be,
    output logic [31:0] write_data,
    output logic [31:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = read_word[7:0];
        case (offset)
            2'd1:    lane_byte = read_word[15:8];
            2'd2:    lane_byte = read_word[23:16];
            2'd3:    lane_byte = read_word[31:24];
            default: lane_byte = read_word[7:0];
        endcase
        lane_half = offset[1] ? read_word[31:16] : read_word[15:0];
    end

    // Reads always fetch the whole word; only stores narrow the byte enables.
    always_comb begin
        be         = 4'b1111;
        write_data = store_data;
        load_data  = read_word;
        case (size)
            SZ_BYTE: begin
                if (write) be = 4'b0001 << offset;
                write_data = {4{store_data[7:0]}};
                load_data  = {{24{lane_byte[7]}}, lane_byte};
            end
            SZ_HALF: begin
                if (write) be = offset[1] ? 4'b1100 : 4'b0011;
                write_data = {2{store_data[15:0]}};
                load_data  = {{16{lane_half[15]}}, lane_half};
            end
            default: begin
                be         = 4'b1111;
                write_data = store_data;
                load_data  = read_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Runs one data-memory transaction per accepted request over a req/ack handshake,
// stalling the pipeline via Busy and reporting alignment and timeout errors with Done.
module mem_access_unit
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Start,
    input  logic          MemRead,
    input  logic [1:0]    MemWrite,
    input  logic [1:0]    MuxLoad,
    input  logic [1:0]    MuxStore,
    input  logic [AW-1:0] Addr,
    input  logic [31:0]   StoreData,
    output logic          Busy,
    output logic          Done,
    output logic [31:0]   LoadData,
    output logic          AddrErr,
    output logic          BusErr,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [3:0]    MemBE,
    output logic [31:0]   MemWData,
    input  logic          MemAck,
    input  logic [31:0]   MemRData
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    state_t        next_state;
    logic          is_read;
    logic          is_write;
    logic          no_access;
    logic          illegal;
    logic [1:0]    req_size;
    logic          accept;
    logic          in_req;
    logic          timeout_hit;
    logic [CW-1:0] wait_cnt;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          write_q;
    logic [31:0]   store_q;
    logic          addr_err_q;
    logic          bus_err_q;
    logic [31:0]   load_q;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata;
    logic [31:0]   lane_load;
    logic          unused_bits;

    // MemWrite[1] is reserved and carries no meaning here.
    assign unused_bits = MemWrite[1];

    assign is_read     = MemRead;
    assign is_write    = MemWrite[0];
    assign no_access   = !is_read && !is_write;
    assign req_size    = is_write ? MuxStore : MuxLoad;
    assign illegal     = (is_read && is_write) || !size_ok(req_size, Addr[1:0]);
    assign accept      = (state == ST_IDLE) && Start;
    assign in_req      = (state == ST_REQ);
    assign timeout_hit = (wait_cnt == CNT_LAST);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Rejected and empty requests skip straight to the Done cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (Start) next_state = (no_access || illegal) ? ST_RESP : ST_REQ;
            ST_REQ:  if (MemAck || timeout_hit) next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Ack takes priority over the final timeout cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            addr_q     <= '0;
            size_q     <= SZ_WORD;
            write_q    <= 1'b0;
            store_q    <= '0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
            wait_cnt   <= '0;
            load_q     <= '0;
        end else if (accept) begin
            addr_q     <= Addr;
            size_q     <= req_size;
            write_q    <= is_write;
            store_q    <= StoreData;
            addr_err_q <= !no_access && illegal;
            bus_err_q  <= 1'b0;
            wait_cnt   <= '0;
        end else if (in_req) begin
            if (MemAck) begin
                if (!write_q) load_q <= lane_load;
            end else if (timeout_hit) begin
                bus_err_q <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    lane_align u_lane_align (
        .size       (size_q),
        .offset     (addr_q[1:0]),
        .write      (write_q),
        .store_data (store_q),
        .read_word  (MemRData),
        .be         (lane_be),
        .write_data (lane_wdata),
        .load_data  (lane_load)
    );

    assign Busy     = in_req;
    assign MemReq   = in_req;
    assign Done     = (state == ST_RESP);
    assign AddrErr  = Done && addr_err_q;
    assign BusErr   = Done && bus_err_q;
    assign MemWe    = in_req && write_q;
    assign MemAddr  = in_req ? {addr_q[AW-1:2], 2'b00} : '0;
    assign MemBE    = in_req ? lane_be : 4'b0000;
    assign MemWData = in_req ? lane_wdata : 32'h0;
    assign LoadData = load_q;

endmodule
